sillyfunction_vector_runner: RTL and testbench

Synthesizable stimulus-and-check engine for the `sillyfunction` combinational block (inputs `a`, `b`, `c`; output `y`). It steps the eight input combinations {a,b,c} = 000..111 in ascending order, waits a programmable settle time, samples `y` and compares it against a parameterized truth table. It accumulates an error count and records the first failing vector, so `sillyfunction` can be checked on the FPGA rather than only in simulation. It sits directly upstream of `sillyfunction`, driving its inputs, and directly downstream of it, consuming `y`.

---
 rtl/sillyfunction_vector_runner.sv | 118 +++++++++++
 tb/tb_sillyfunction_vector_runner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sillyfunction_vector_runner.sv
// Purpose: steps {a,b,c} through 000..111, samples y after a settle delay, and tallies mismatches against EXPECTED.
// Latency: 8*(SETTLE_CYCLES+2) cycles from start acceptance to the done pulse. Backpressure: none; start is sampled only in IDLE and is not queued.
module sillyfunction_vector_runner #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'h31
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] abc_q, abc_d;
    logic [3:0] err_q, err_d;
    logic [2:0] ff_q, ff_d;
    logic       pass_q, pass_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        abc_d   = abc_q;
        err_d   = err_q;
        ff_d    = ff_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    idx_d   = 3'd0;
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                abc_d   = idx_q;
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                // At most eight increments per run, so four bits never wrap.
                if (y != EXPECTED[idx_q]) begin
                    err_d = err_q + 4'd1;
                    if (err_q == 4'd0) begin
                        ff_d = idx_q;
                    end
                end
                if (idx_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_APPLY;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == 4'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            abc_q   <= 3'd0;
            err_q   <= 4'd0;
            ff_q    <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign a          = abc_q[2];
    assign b          = abc_q[1];
    assign c          = abc_q[0];
    assign busy       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_sillyfunction_vector_runner.sv
// Four runners (S=2 with EXPECTED 31/30/CE, S=1 with 31) each driving a correct sillyfunction,
// checked every cycle against a run-timeline model plus directed literal expectations.
module tb_sillyfunction_vector_runner;

    localparam logic [31:0] EXPS = {8'h31, 8'hCE, 8'h30, 8'h31};

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_r [4];
    logic       y_w     [4];
    logic       a_w     [4];
    logic       b_w     [4];
    logic       c_w     [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    logic       pass_w  [4];
    logic [3:0] err_w   [4];
    logic [2:0] ff_w    [4];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt [4];
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        assign y_w[gi] = (~b_w[gi] & ~c_w[gi]) | (a_w[gi] & ~b_w[gi]);
        sillyfunction_vector_runner #(
            .SETTLE_CYCLES ((gi == 3) ? 1 : 2),
            .EXPECTED      (EXPS[gi*8 +: 8])
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .start      (start_r[gi]),
            .y          (y_w[gi]),
            .a          (a_w[gi]),
            .b          (b_w[gi]),
            .c          (c_w[gi]),
            .busy       (busy_w[gi]),
            .done       (done_w[gi]),
            .pass       (pass_w[gi]),
            .err_count  (err_w[gi]),
            .first_fail (ff_w[gi])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int s_of(input int i);
        return (i == 3) ? 1 : 2;
    endfunction

    function automatic logic exp_bit(input int i, input int k);
        logic [31:0] e;
        e = EXPS;
        return e[i*8 + k];
    endfunction

    // Reference sillyfunction evaluated on vector index k = {a,b,c}.
    function automatic logic ref_y(input int k);
        logic [2:0] v;
        v = k[2:0];
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    // Model position n: 0 = idle; n = 1 + edges since the accepting edge while a run is in flight.
    int         m_n    [4];
    logic [2:0] m_abc  [4];
    logic [3:0] m_err  [4];
    logic [2:0] m_ff   [4];
    logic       m_pass [4];

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                for (int i = 0; i < 4; i++) begin
                    m_n[i] = 0; m_abc[i] = 0; m_err[i] = 0; m_ff[i] = 0; m_pass[i] = 0;
                end
            end else begin
                cyc++;
                for (int i = 0; i < 4; i++) begin
                    int p, len;
                    p   = s_of(i) + 2;
                    len = 8 * p;
                    if (m_n[i] == 0) begin
                        if (start_r[i]) begin
                            m_n[i] = 1; m_err[i] = 0; m_pass[i] = 0;
                        end
                    end else if (m_n[i] == len + 1) begin
                        m_pass[i] = (m_err[i] == 0);
                        m_n[i]    = 0;
                    end else begin
                        m_n[i]++;
                        if ((m_n[i] - 1) % p == 0) begin
                            int k;
                            k = (m_n[i] - 1) / p - 1;
                            if (ref_y(k) != exp_bit(i, k)) begin
                                if (m_err[i] == 0) m_ff[i] = 3'(k);
                                m_err[i] = m_err[i] + 4'd1;
                            end
                        end
                        if (m_n[i] >= 2) m_abc[i] = 3'((m_n[i] - 2) / p);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (done_w[i]) done_cnt[i]++;
                if (chk_en) begin
                    int len;
                    len = 8 * (s_of(i) + 2);
                    chk($sformatf("abc[%0d]", i), {a_w[i], b_w[i], c_w[i]}, m_abc[i]);
                    chk($sformatf("busy[%0d]", i), busy_w[i], (m_n[i] >= 1 && m_n[i] <= len) ? 1 : 0);
                    chk($sformatf("done[%0d]", i), done_w[i], (m_n[i] == len + 1) ? 1 : 0);
                    chk($sformatf("pass[%0d]", i), pass_w[i], m_pass[i]);
                    chk($sformatf("err[%0d]", i), err_w[i], m_err[i]);
                    if (m_err[i] != 0) chk($sformatf("ff[%0d]", i), ff_w[i], m_ff[i]);
                end
            end
        end
    end

    // Pulses start for runner i, then counts edges after the accepting edge until done is seen.
    task automatic run_wait(input int i, input int poke_at, output int lat);
        @(negedge clk);
        start_r[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[i] = 1'b0;
        lat = 0;
        while (!done_w[i] && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            start_r[i] = (lat == poke_at);
        end
        start_r[i] = 1'b0;
        if (lat >= 300) chk($sformatf("timeout run %0d", i), 0, 1);
    endtask

    initial begin
        int lat, d0, t_prev, t_now;
        for (int i = 0; i < 4; i++) begin
            start_r[i] = 1'b0;
            done_cnt[i] = 0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset abc", {a_w[0], b_w[0], c_w[0]}, 0);
        chk("reset busy", busy_w[0], 0);
        chk("reset done", done_w[0], 0);
        chk("reset pass", pass_w[0], 0);
        chk("reset err", err_w[0], 0);
        chk("reset ff", ff_w[0], 0);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Clean run, S=2: done visible right after edge E0+32.
        d0 = done_cnt[0];
        run_wait(0, -1, lat);
        chk("t1 latency", lat, 32);
        @(negedge clk);
        chk("t1 err", err_w[0], 0);
        chk("t1 pass", pass_w[0], 1);
        chk("t1 done count", done_cnt[0] - d0, 1);
        chk("t1 abc hold", {a_w[0], b_w[0], c_w[0]}, 7);

        run_wait(1, -1, lat);
        @(negedge clk);
        chk("t2 err", err_w[1], 1);
        chk("t2 ff", ff_w[1], 0);
        chk("t2 pass", pass_w[1], 0);

        run_wait(2, -1, lat);
        @(negedge clk);
        chk("t3 err", err_w[2], 8);
        chk("t3 ff", ff_w[2], 0);
        chk("t3 pass", pass_w[2], 0);

        // Extra start during vector 3's settle is ignored.
        d0 = done_cnt[0];
        run_wait(0, 14, lat);
        chk("t4 latency", lat, 32);
        repeat (5) @(negedge clk);
        chk("t4 done count", done_cnt[0] - d0, 1);
        chk("t4 err", err_w[0], 0);
        chk("t4 pass", pass_w[0], 1);

        // Reset during vector 5 settle (vector 5 driven at E0+21).
        d0 = done_cnt[0];
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (22) @(negedge clk);
        chk("t5 pre abc", {a_w[0], b_w[0], c_w[0]}, 5);
        #2 reset_n = 1'b0;
        #1;
        chk("t5 abc", {a_w[0], b_w[0], c_w[0]}, 0);
        chk("t5 busy", busy_w[0], 0);
        chk("t5 err", err_w[0], 0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5 no done", done_cnt[0] - d0, 0);
        run_wait(0, -1, lat);
        chk("t5 rerun latency", lat, 32);
        @(negedge clk);
        chk("t5 rerun pass", pass_w[0], 1);

        // S=1 with start held: 24 run cycles + DONE + IDLE between accepts.
        @(negedge clk);
        start_r[3] = 1'b1;
        t_prev = -1;
        for (int r = 0; r < 3; r++) begin
            int guard;
            guard = 0;
            while (!done_w[3] && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) chk("t6 timeout", 0, 1);
            t_now = cyc;
            if (t_prev >= 0) chk("t6 period", t_now - t_prev, 26);
            t_prev = t_now;
            @(negedge clk);
            chk("t6 pass", pass_w[3], 1);
        end
        start_r[3] = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
